// File: rtl/mem_access_stage.sv
// MEM pipeline stage and MEM/WB boundary: runs loads/stores over a req/ack data bus,
// aligns and extends load data, stalls while the bus is busy and flags misaligned accesses.
module mem_access_stage #(
  parameter logic [7:0] OP_LB  = 8'b11100000,
  parameter logic [7:0] OP_LBU = 8'b11100100,
  parameter logic [7:0] OP_LH  = 8'b11100001,
  parameter logic [7:0] OP_LHU = 8'b11100101,
  parameter logic [7:0] OP_LW  = 8'b11100011,
  parameter logic [7:0] OP_SB  = 8'b11101000,
  parameter logic [7:0] OP_SH  = 8'b11101001,
  parameter logic [7:0] OP_SW  = 8'b11101011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [31:0] mem_pc,
  input  logic        flush,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_sel,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        stall_req,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr,
  output logic [31:0] exc_pc
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_reg;
  logic        flush_pending_reg;
  logic        is_load_reg;
  logic        sign_reg;
  size_t       size_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] load_data_reg;

  logic        is_load, is_store, is_mem, sign_ext, misaligned;
  size_t       size;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;
  logic [7:0]  rbyte [4];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    case (mem_aluop)
      OP_LB:   begin is_load = 1'b1;  sign_ext = 1'b1; size = SZ_BYTE; end
      OP_LBU:  begin is_load = 1'b1;  size = SZ_BYTE; end
      OP_LH:   begin is_load = 1'b1;  sign_ext = 1'b1; size = SZ_HALF; end
      OP_LHU:  begin is_load = 1'b1;  size = SZ_HALF; end
      OP_LW:   begin is_load = 1'b1;  size = SZ_WORD; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: begin is_load = 1'b0; end
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem &&
                      (((size == SZ_HALF) && mem_mem_addr[0]) ||
                       ((size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00)));

  always_comb begin
    sel_next   = 4'b1111;
    wdata_next = mem_reg2;
    case (size)
      SZ_BYTE: begin
        sel_next   = 4'b0001 << mem_mem_addr[1:0];
        wdata_next = {4{mem_reg2[7:0]}};
      end
      SZ_HALF: begin
        sel_next   = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_reg2[15:0]}};
      end
      default: begin
        sel_next   = 4'b1111;
        wdata_next = mem_reg2;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = d_rdata[8*gi +: 8];
  end

  // Lane selection uses the address captured at issue, not the live input.
  always_comb begin
    load_ext = d_rdata;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{sign_reg & rbyte[addr_lo_reg][7]}}, rbyte[addr_lo_reg]};
      SZ_HALF: load_ext = addr_lo_reg[1] ?
                          {{16{sign_reg & d_rdata[31]}}, d_rdata[31:16]} :
                          {{16{sign_reg & d_rdata[15]}}, d_rdata[15:0]};
      default: load_ext = d_rdata;
    endcase
  end

  assign stall_req = ~rst &
                     (((state_reg == IDLE) && is_mem && !misaligned && !flush) ||
                      (state_reg == BUS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      flush_pending_reg <= 1'b0;
      is_load_reg       <= 1'b0;
      sign_reg          <= 1'b0;
      size_reg          <= SZ_BYTE;
      addr_lo_reg       <= 2'b00;
      load_data_reg     <= 32'h0;
      d_req             <= 1'b0;
      d_we              <= 1'b0;
      d_addr            <= 32'h0;
      d_sel             <= 4'h0;
      d_wdata           <= 32'h0;
      wb_wd             <= 5'h0;
      wb_wreg           <= 1'b0;
      wb_wdata          <= 32'h0;
      exc_adel          <= 1'b0;
      exc_ades          <= 1'b0;
      exc_badvaddr      <= 32'h0;
      exc_pc            <= 32'h0;
    end else begin
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (flush) begin
            wb_wreg <= 1'b0;
          end else if (misaligned) begin
            wb_wreg      <= 1'b0;
            exc_adel     <= is_load;
            exc_ades     <= is_store;
            exc_badvaddr <= mem_mem_addr;
            exc_pc       <= mem_pc;
          end else if (is_mem) begin
            state_reg         <= BUS;
            flush_pending_reg <= 1'b0;
            is_load_reg       <= is_load;
            sign_reg          <= sign_ext;
            size_reg          <= size;
            addr_lo_reg       <= mem_mem_addr[1:0];
            d_req             <= 1'b1;
            d_we              <= is_store;
            d_addr            <= {mem_mem_addr[31:2], 2'b00};
            d_sel             <= sel_next;
            d_wdata           <= wdata_next;
            wb_wreg           <= 1'b0;
          end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end
        end
        BUS: begin
          // A flush seen mid-transfer only suppresses the write-back.
          if (flush) flush_pending_reg <= 1'b1;
          if (d_ack) begin
            d_req         <= 1'b0;
            load_data_reg <= load_ext;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          wb_wd             <= mem_wd;
          wb_wreg           <= mem_wreg & ~flush & ~flush_pending_reg;
          wb_wdata          <= is_load_reg ? load_data_reg : mem_wdata;
          flush_pending_reg <= 1'b0;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: hand-computed expectations for loads, stores,
// misalignment, flush, reset mid-transfer and back-to-back operation.
module tb_mem_access_stage;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;
  localparam logic [7:0] OP_ADD = 8'b00100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_pc;
  logic        flush;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;
  logic [31:0] exc_pc;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_pc(mem_pc), .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_req(stall_req),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_badvaddr(exc_badvaddr), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are observed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        input logic [4:0] wd, input logic wreg);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = wdata;
    mem_pc       = pc;
    mem_wd       = wd;
    mem_wreg     = wreg;
    #1;
  endtask

  task automatic idle_op();
    set_op(OP_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; d_ack = 1'b0; d_rdata = 32'h0;
    idle_op();
    tick(); tick();
    chk("rst_dreq", {31'b0, d_req}, 32'h0);
    chk("rst_wbwreg", {31'b0, wb_wreg}, 32'h0);
    chk("rst_wbdata", wb_wdata, 32'h0);
    chk("rst_stall", {31'b0, stall_req}, 32'h0);
    rst = 1'b0;
    tick();
    $display("txn reset_idle done");

    // LB at 0x1003 with ack in the first BUS cycle
    set_op(OP_LB, 32'h0000_1003, 32'h0, 32'h1111_1111, 32'h0000_0100, 5'd3, 1'b1);
    chk("lb_stall_issue", {31'b0, stall_req}, 32'h1);
    tick();
    chk("lb_dreq", {31'b0, d_req}, 32'h1);
    chk("lb_dsel", {28'b0, d_sel}, 32'h8);
    chk("lb_daddr", d_addr, 32'h0000_1000);
    chk("lb_dwe", {31'b0, d_we}, 32'h0);
    chk("lb_bubble", {31'b0, wb_wreg}, 32'h0);
    chk("lb_stall_bus", {31'b0, stall_req}, 32'h1);
    d_ack = 1'b1; d_rdata = 32'h80AA_BBCC;
    tick();
    d_ack = 1'b0;
    #1;
    chk("lb_dreq_fall", {31'b0, d_req}, 32'h0);
    chk("lb_stall_done", {31'b0, stall_req}, 32'h0);
    tick();
    chk("lb_wbwreg", {31'b0, wb_wreg}, 32'h1);
    chk("lb_wbdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_wbwd", {27'b0, wb_wd}, 32'd3);
    $display("txn LB addr=00001003 wb=%h", wb_wdata);

    // SH at 0x2002 issued back-to-back, ack delayed by 3 cycles
    set_op(OP_SH, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_0000, 32'h0000_0104, 5'd0, 1'b0);
    chk("sh_stall_issue", {31'b0, stall_req}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sh_dreq_wait", {31'b0, d_req}, 32'h1);
      chk("sh_dwe", {31'b0, d_we}, 32'h1);
      chk("sh_dsel", {28'b0, d_sel}, 32'hC);
      chk("sh_dwdata", d_wdata, 32'hABCD_ABCD);
      chk("sh_daddr", d_addr, 32'h0000_2000);
      tick();
    end
    chk("sh_dreq_last", {31'b0, d_req}, 32'h1);
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    #1;
    chk("sh_dreq_fall", {31'b0, d_req}, 32'h0);
    tick();
    chk("sh_wbwreg", {31'b0, wb_wreg}, 32'h0);
    chk("sh_wbdata", wb_wdata, 32'h5555_0000);
    $display("txn SH addr=00002002 data=%h", 32'hABCD_ABCD);

    // Misaligned LW -> address error on load
    set_op(OP_LW, 32'h0000_0006, 32'h0, 32'h0, 32'h0000_0200, 5'd4, 1'b1);
    chk("lw_mis_stall", {31'b0, stall_req}, 32'h0);
    tick();
    chk("lw_mis_adel", {31'b0, exc_adel}, 32'h1);
    chk("lw_mis_ades", {31'b0, exc_ades}, 32'h0);
    chk("lw_mis_badv", exc_badvaddr, 32'h0000_0006);
    chk("lw_mis_pc", exc_pc, 32'h0000_0200);
    chk("lw_mis_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("lw_mis_dreq", {31'b0, d_req}, 32'h0);
    idle_op();
    tick();
    chk("lw_mis_pulse_end", {31'b0, exc_adel}, 32'h0);
    $display("txn LW misaligned addr=00000006");

    // Misaligned SW -> address error on store
    set_op(OP_SW, 32'h0000_0011, 32'h0, 32'h0, 32'h0000_0300, 5'd0, 1'b0);
    tick();
    chk("sw_mis_ades", {31'b0, exc_ades}, 32'h1);
    chk("sw_mis_adel", {31'b0, exc_adel}, 32'h0);
    chk("sw_mis_badv", exc_badvaddr, 32'h0000_0011);
    idle_op();
    tick();
    $display("txn SW misaligned addr=00000011");

    // Flush during BUS of LHU
    set_op(OP_LHU, 32'h0000_4002, 32'h0, 32'h0, 32'h0000_0400, 5'd6, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_dreq_held", {31'b0, d_req}, 32'h1);
    chk("fl_stall_bus", {31'b0, stall_req}, 32'h1);
    d_ack = 1'b1; d_rdata = 32'h8765_4321;
    tick();
    d_ack = 1'b0;
    #1;
    chk("fl_dreq_fall", {31'b0, d_req}, 32'h0);
    chk("fl_stall_done", {31'b0, stall_req}, 32'h0);
    tick();
    chk("fl_wbwreg", {31'b0, wb_wreg}, 32'h0);
    chk("fl_noexc", {30'b0, exc_adel, exc_ades}, 32'h0);
    idle_op();
    tick();
    $display("txn LHU flushed addr=00004002");

    // ADD then LBU back-to-back
    set_op(OP_ADD, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0500, 5'd7, 1'b1);
    chk("add_stall", {31'b0, stall_req}, 32'h0);
    tick();
    chk("add_wbwreg", {31'b0, wb_wreg}, 32'h1);
    chk("add_wbdata", wb_wdata, 32'hDEAD_BEEF);
    chk("add_wbwd", {27'b0, wb_wd}, 32'd7);
    $display("txn ADD wb=%h", wb_wdata);
    set_op(OP_LBU, 32'h0000_3001, 32'h0, 32'h0, 32'h0000_0504, 5'd9, 1'b1);
    tick();
    chk("lbu_dsel", {28'b0, d_sel}, 32'h2);
    d_ack = 1'b1; d_rdata = 32'h0000_FE00;
    tick();
    d_ack = 1'b0;
    tick();
    chk("lbu_wbwreg", {31'b0, wb_wreg}, 32'h1);
    chk("lbu_wbdata", wb_wdata, 32'h0000_00FE);
    chk("lbu_wbwd", {27'b0, wb_wd}, 32'd9);
    $display("txn LBU addr=00003001 wb=%h", wb_wdata);

    // Reset while a transfer is outstanding; a late ack must be ignored
    set_op(OP_LW, 32'h0000_5000, 32'h0, 32'h0, 32'h0000_0600, 5'd10, 1'b1);
    tick();
    chk("rb_dreq_bus", {31'b0, d_req}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rb_dreq", {31'b0, d_req}, 32'h0);
    chk("rb_wbwreg", {31'b0, wb_wreg}, 32'h0);
    chk("rb_wbdata", wb_wdata, 32'h0);
    chk("rb_exc", {30'b0, exc_adel, exc_ades}, 32'h0);
    rst = 1'b0;
    idle_op();
    chk("rb_stall_idle", {31'b0, stall_req}, 32'h0);
    d_ack = 1'b1; d_rdata = 32'hFFFF_FFFF;
    tick();
    d_ack = 1'b0;
    #1;
    chk("rb_late_ack_dreq", {31'b0, d_req}, 32'h0);
    chk("rb_late_ack_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("rb_late_ack_stall", {31'b0, stall_req}, 32'h0);
    $display("txn LW reset mid-transfer");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
